// File: rtl/seg_time_pkg.sv
// Shared constants and types for the 7-segment time readback decoder:
// canonical segment patterns (active-high, bit6..0 = g..a), FSM states, BCD limits.
package seg_time_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [7:0] HOUR_MAX      = 8'h23;
    localparam logic [3:0] HOUR_TENS_MAX = 4'd2;
    localparam logic [3:0] MIN_TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, REJECT} seg_state_e;

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
    } bcd_time_t;

    // Hour advance wraps 23 -> 00.
    function automatic logic [7:0] bcd_inc_hour(input logic [7:0] h);
        if (h >= HOUR_MAX)
            return 8'h00;
        if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic bcd_time_t bcd_inc_minute(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.min[3:0] != 4'd9) begin
            r.min[3:0] = t.min[3:0] + 4'd1;
        end else begin
            r.min[3:0] = 4'd0;
            if (t.min[7:4] != MIN_TENS_MAX) begin
                r.min[7:4] = t.min[7:4] + 4'd1;
            end else begin
                r.min[7:4] = 4'd0;
                r.hour     = bcd_inc_hour(t.hour);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// One 7-segment digit to BCD value; flags canonical match and the all-dark pattern.
module seg7_digit_decode
    import seg_time_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [6:0] seg,
    output logic       valid,
    output logic       blank,
    output logic [3:0] value
);

    logic [6:0] lit;

    assign lit   = SEG_ACTIVE_LOW ? ~seg : seg;
    assign blank = (lit == SEG_BLANK);

    always_comb begin
        valid = 1'b1;
        value = 4'd0;
        case (lit)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_time_decoder.sv
// Recovers HH:MM from the four HEX segment buses with stability filtering and range
// checks. Define SEG_TIME_ROLLOVER_CHECK_EN to build the non-sequential update check.
module seg_time_decoder
    import seg_time_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int ERR_W          = 8
) (
    input  logic             CP50,
    input  logic             CR,
    input  logic [6:0]       HEX0,
    input  logic [6:0]       HEX1,
    input  logic [6:0]       HEX2,
    input  logic [6:0]       HEX3,
    output logic [7:0]       hour_bcd,
    output logic [7:0]       min_bcd,
    output logic             time_valid,
    output logic             time_upd,
    output logic             decode_err,
    output logic [ERR_W-1:0] err_count,
    output logic             seq_err
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0][6:0] hex_q, hex_p;
    logic [NUM_DIGITS-1:0]      dvalid, dblank, dig_ok;
    logic [NUM_DIGITS-1:0][3:0] dval;
    logic [7:0]                 cnt, cnt_nxt;
    seg_state_e                 state;
    bcd_time_t                  held, cand;
    logic                       eq, pass, eval, accept, upd_now;

    // Same clock domain as the encoder, so one register stage is enough.
    always_ff @(posedge CP50 or posedge CR) begin
        if (CR) begin
            hex_q <= '0;
            hex_p <= '0;
        end else begin
            hex_q <= {HEX3, HEX2, HEX1, HEX0};
            hex_p <= hex_q;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
        seg7_digit_decode #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
            .seg   (hex_q[i]),
            .valid (dvalid[i]),
            .blank (dblank[i]),
            .value (dval[i])
        );
        // Only the hour-tens digit may be dark (leading-zero suppression).
        assign dig_ok[i] = dvalid[i] | (dblank[i] & (i == NUM_DIGITS-1));
    end

    assign cand = {dval[3], dval[2], dval[1], dval[0]};
    assign pass = (&dig_ok) && (dval[3] <= HOUR_TENS_MAX) &&
                  (cand.hour <= HOUR_MAX) && (dval[1] <= MIN_TENS_MAX);

    assign eq = (hex_q == hex_p);

    always_comb begin
        cnt_nxt = 8'd1;
        if (eq)
            cnt_nxt = (cnt >= STABLE_C) ? STABLE_C : cnt + 8'd1;
    end

    // The snapshot must still match at the evaluation edge, so the value used is
    // the one already confirmed by the count.
    assign eval    = (state == SETTLE) && eq && (cnt == STABLE_C);
    assign accept  = eval && pass;
    assign upd_now = accept && (!time_valid || (cand != held));

    always_ff @(posedge CP50 or posedge CR) begin
        if (CR) begin
            state      <= IDLE;
            cnt        <= '0;
            held       <= '0;
            time_valid <= 1'b0;
            time_upd   <= 1'b0;
            decode_err <= 1'b0;
            err_count  <= '0;
        end else begin
            time_upd   <= upd_now;
            decode_err <= eval && !pass;
            if (eval && !pass && (err_count != '1))
                err_count <= err_count + ERR_W'(1);
            if (accept) begin
                held       <= cand;
                time_valid <= 1'b1;
            end
            case (state)
                IDLE: state <= SETTLE;
                SETTLE: begin
                    cnt <= cnt_nxt;
                    if (eval)
                        state <= pass ? LOCKED : REJECT;
                end
                LOCKED, REJECT: begin
                    cnt <= cnt_nxt;
                    if (!eq)
                        state <= SETTLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hour_bcd = held.hour;
    assign min_bcd  = held.min;

`ifdef SEG_TIME_ROLLOVER_CHECK_EN
    bcd_time_t next_min;
    logic      seq_ok;

    // Legal steps: +1 minute with carry, or hour-only +1 (manual hour adjust).
    assign next_min = bcd_inc_minute(held);
    assign seq_ok   = (cand == next_min) ||
                      ((cand.min == held.min) && (cand.hour == bcd_inc_hour(held.hour)));

    always_ff @(posedge CP50 or posedge CR) begin
        if (CR)
            seq_err <= 1'b0;
        else
            seq_err <= upd_now && time_valid && !seq_ok;
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: doc/seg_time_decoder.md
Name: seg_time_decoder

Overview:
- Receive-side counterpart of the clock's 7-segment encoder: samples the four HEX digit buses (HEX3..HEX0 = hour tens, hour ones, minute tens, minute ones) and recovers the displayed time as packed BCD.
- Filters transient or glitched segment patterns, range-checks the time and raises a one-cycle strobe on each newly accepted time.
- Sits beside the clock core as a self-check / readback monitor, usable in silicon and in benches.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples needed before a pattern is accepted; legal range 1..255.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when bit is 0; 0 = lit when 1.
- ERR_W, 8: width of the saturating error counter.

Ports:
- CP50  in  1  system clock, all logic on rising edge.
- CR  in  1  asynchronous active-high reset.
- HEX0  in  7  minute ones segments, bit6..bit0 = g,f,e,d,c,b,a.
- HEX1  in  7  minute tens segments.
- HEX2  in  7  hour ones segments.
- HEX3  in  7  hour tens segments.
- hour_bcd  out  8  accepted hours, {tens,ones}.
- min_bcd  out  8  accepted minutes, {tens,ones}.
- time_valid  out  1  high once any time has been accepted.
- time_upd  out  1  one-cycle pulse when hour_bcd/min_bcd change.
- decode_err  out  1  one-cycle pulse when a stable pattern is rejected.
- err_count  out  ERR_W  saturating count of decode_err pulses.
- seq_err  out  1  one-cycle pulse on a non-sequential update (see Optional Feature).

Behaviour:
- Reset (CR=1, asynchronous): hour_bcd=8'h00, min_bcd=8'h00, time_valid=0, time_upd=0, decode_err=0, err_count=0, seq_err=0, FSM=IDLE, stability counter=0.
- Input stage: HEX0..3 are registered once, with no metastability synchroniser because they come from the same clock domain. Each registered digit is decoded combinationally to a 4-bit value.
  - The 10 canonical digit patterns map to 0..9.
  - Any other pattern is invalid.
  - A blank digit (no segments lit) is legal on HEX3 only and decodes to 0. On any other digit a blank is invalid.
- Stability: a 28-bit snapshot {HEX3..HEX0} is compared with the previous sample.
  - Equal: the counter increments, saturating at STABLE_CYCLES.
  - Different: the counter reloads to 1.
- FSM states:
  - IDLE: reset state. Goes to SETTLE on the first sample.
  - SETTLE: waiting for the counter to reach STABLE_CYCLES. On reaching it, evaluate the pattern:
    - Pass: load the outputs, pulse time_upd if the value differs from the held value or time_valid was 0, set time_valid=1, go to LOCKED.
    - Fail: pulse decode_err once, increment err_count, go to REJECT.
  - LOCKED: stay while the snapshot is unchanged. Any change goes to SETTLE.
  - REJECT: stay while the snapshot is unchanged, so there is no repeated error for the same pattern. Any change goes to SETTLE.
- Evaluation passes only if all of the following hold:
  - every digit is valid;
  - hour tens ≤ 2;
  - hours ≤ 23 (12-hour display values 01..12 are a subset of this);
  - minute tens ≤ 5.
- Latency: a change on HEX appears on hour_bcd/min_bcd with time_upd exactly STABLE_CYCLES+1 cycles after the first edge at which the new pattern is present.
- Outputs hold their last accepted value through SETTLE and REJECT. time_valid never falls except on reset.
- Boundaries:
  - err_count saturates at all-ones.
  - A pattern that re-stabilises to the same accepted value gives no time_upd.
  - CR asserted mid-SETTLE discards the partial count.
  - A glitch of fewer than STABLE_CYCLES cycles produces no output activity.

Optional Feature:
- Macro: SEG_TIME_ROLLOVER_CHECK_EN.
- Defined: on each time_upd after the first, compare the new time with the previous accepted time.
  - Allowed: equal to previous+1 minute (59→00 carries the hour, 23:59→00:00), or the hour alone changed by +1 with the same minutes (covers AdjH).
  - Anything else pulses seq_err in the same cycle as time_upd.
- Undefined: seq_err is tied 0 and no comparison logic is built.

Decomposition:
- Shared package seg_time_pkg holds:
  - the 10 canonical segment constants (active-high form);
  - the SEG_BLANK constant;
  - the FSM state enum {IDLE, SETTLE, LOCKED, REJECT};
  - the BCD limits: HOUR_MAX=8'h23, MIN_TENS_MAX=5.
- One natural sub-module, seg7_digit_decode: 7-bit pattern in, {valid, blank, value[3:0]} out, with SEG_ACTIVE_LOW applied. It is instantiated four times.

Test Plan (STABLE_CYCLES=4, active-low):
- Reset then HEX3..0 = 1111111,0100100,0110000,0010010 ("_2:35") held → after 5 cycles hour_bcd=8'h02, min_bcd=8'h35, time_upd pulses once, time_valid=1.
- From 12:59, apply a 2-cycle glitch to HEX0=0000000, then return → no time_upd, no decode_err, outputs unchanged.
- HEX1 = 0000010 (6 as minute tens) held 10 cycles → one decode_err, err_count=1, outputs hold the prior value.
- CR pulse asserted mid-SETTLE (cycle 2) → all outputs 0 immediately and asynchronously; the pattern is re-accepted 5 cycles after CR falls.
- With SEG_TIME_ROLLOVER_CHECK_EN: 23:59 → 00:00 gives time_upd and seq_err=0; then 00:00 → 00:07 gives time_upd and seq_err=1.
- Cycle through 256+ invalid patterns, each separated by a valid time → err_count saturates at 8'hFF.
